tick_scheduler: RTL and testbench

//  Central timebase for the game logic. Divides clk into one shared base tick.

---
 rtl/tick_scheduler.sv | 162 ++++++++++++++++
 tb/tb_tick_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared base-tick prescaler plus NCH software timer channels.
// Each channel counts base ticks down from a programmable period and emits a
// single-cycle ch_tick on expiry, in one-shot or periodic mode.
// Optional feature: define TICK_SCHED_FLAG_EN to build sticky per-channel
// expiry flags (ch_flag/flag_clr); otherwise ch_flag is tied to 0.
module tick_scheduler #(
  parameter int unsigned CLK_DIV = 200_000,
  parameter int unsigned NCH     = 4,
  parameter int unsigned PW      = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pause,
  input  logic           cfg_we,
  input  logic [2:0]     cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           cfg_oneshot,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic           cfg_err,
  output logic           tick_o,
  output logic [NCH-1:0] ch_tick,
  output logic [NCH-1:0] ch_busy,
  output logic [NCH-1:0] ch_flag,
  input  logic [NCH-1:0] flag_clr
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] PcntMax = CW'(CLK_DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} ch_state_e;

  logic [CW-1:0]  pcnt_q, pcnt_d;
  logic           base_tick;
  logic           tick_q;
  logic           cfg_err_q, cfg_err_d;
  logic [NCH-1:0] cfg_sel, cfg_ok;
  logic [NCH-1:0] expire, ch_tick_q;

  ch_state_e      state_q [NCH];
  ch_state_e      state_d [NCH];
  logic [PW-1:0]  count_q [NCH];
  logic [PW-1:0]  count_d [NCH];
  logic [PW-1:0]  period_q[NCH];
  logic [PW-1:0]  period_d[NCH];
  logic [NCH-1:0] oneshot_q, oneshot_d;

  // Prescaler next state; pause freezes the count and masks the tick.
  always_comb begin
    pcnt_d    = pcnt_q;
    base_tick = (pcnt_q == PcntMax) && !pause;
    if (!pause) begin
      pcnt_d = (pcnt_q == PcntMax) ? '0 : pcnt_q + CW'(1);
    end
  end

  // Decode cfg_we: out-of-range index or a running target is rejected.
  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == 3'(i)) cfg_sel[i] = 1'b1;
    end
    cfg_ok    = '0;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (cfg_sel == '0 || (cfg_sel & ch_busy) != '0) cfg_err_d = 1'b1;
      else                                          cfg_ok    = cfg_sel;
    end
  end

  // Per-channel next state: stop > start > expiry > count down.
  always_comb begin
    oneshot_d = oneshot_q;
    expire    = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];
      if (cfg_ok[i]) begin
        period_d[i]  = cfg_period;
        oneshot_d[i] = cfg_oneshot;
      end
      if (stop[i]) begin
        state_d[i] = StIdle;
        count_d[i] = '0;
      end else if (start[i]) begin
        // A same-cycle config write is already visible in period_d.
        if (period_d[i] != '0) begin
          state_d[i] = StRun;
          count_d[i] = period_d[i];
        end
      end else if (state_q[i] == StRun && base_tick) begin
        if (count_q[i] == PW'(1)) begin
          expire[i] = 1'b1;
          if (oneshot_q[i]) begin
            state_d[i] = StIdle;
            count_d[i] = '0;
          end else begin
            count_d[i] = period_q[i];
          end
        end else begin
          count_d[i] = count_q[i] - PW'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q    <= '0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      ch_tick_q <= '0;
      oneshot_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= StIdle;
        count_q[i]  <= '0;
        period_q[i] <= '0;
      end
    end else begin
      pcnt_q    <= pcnt_d;
      tick_q    <= base_tick;
      cfg_err_q <= cfg_err_d;
      ch_tick_q <= expire;
      oneshot_q <= oneshot_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  // Busy is a direct view of the registered channel state.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_busy[i] = (state_q[i] == StRun);
    end
  end

  assign tick_o  = tick_q;
  assign cfg_err = cfg_err_q;
  assign ch_tick = ch_tick_q;

`ifdef TICK_SCHED_FLAG_EN
  logic [NCH-1:0] flag_q;

  // Sticky flags set from the visible ch_tick pulse; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) flag_q <= '0;
    else     flag_q <= ch_tick_q | (flag_q & ~flag_clr);
  end

  assign ch_flag = flag_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = ^flag_clr;
  assign ch_flag         = '0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler (CLK_DIV=4, NCH=4, PW=8): directed
// scenarios followed by random traffic, all checked against a timer model.
module tb_tick_scheduler;

  localparam int CLK_DIV = 4;
  localparam int NCH     = 4;
  localparam int PW      = 8;

  logic           clk = 1'b0;
  logic           rst, pause, cfg_we, cfg_oneshot;
  logic [2:0]     cfg_ch;
  logic [PW-1:0]  cfg_period;
  logic [NCH-1:0] start, stop, flag_clr;
  logic           cfg_err, tick_o;
  logic [NCH-1:0] ch_tick, ch_busy, ch_flag;

  tick_scheduler #(.CLK_DIV(CLK_DIV), .NCH(NCH), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .cfg_err    (cfg_err),
    .tick_o     (tick_o),
    .ch_tick    (ch_tick),
    .ch_busy    (ch_busy),
    .ch_flag    (ch_flag),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           tick;
    logic [NCH-1:0] cht;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] flag;
    logic           err;
  } obs_t;

  obs_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: a prescaler phase plus, per channel, the number of base
  // ticks left before expiry.
  int             phase;
  bit             run[8];
  int             rem[8];
  int             per[8];
  bit             os[8];
  bit [NCH-1:0]   flag_m;
  bit [NCH-1:0]   last_cht;

  // Apply the current inputs for one clock, push the expected response.
  task automatic step();
    obs_t e;
    bit   bt;
    e = '0;
    if (rst) begin
      phase = 0;
      for (int i = 0; i < 8; i++) begin
        run[i] = 0; rem[i] = 0; per[i] = 0; os[i] = 0;
      end
      flag_m   = '0;
      last_cht = '0;
    end else begin
      bt = (phase == CLK_DIV - 1) && !pause;
      if (!pause) phase = (phase + 1) % CLK_DIV;
      if (cfg_we) begin
        if (int'(cfg_ch) >= NCH || run[cfg_ch]) e.err = 1'b1;
        else begin
          per[cfg_ch] = int'(cfg_period);
          os[cfg_ch]  = cfg_oneshot;
        end
      end
      flag_m = last_cht | (flag_m & ~flag_clr);
      for (int i = 0; i < NCH; i++) begin
        if (stop[i]) begin
          run[i] = 0; rem[i] = 0;
        end else if (start[i]) begin
          if (per[i] != 0) begin
            run[i] = 1; rem[i] = per[i];
          end
        end else if (run[i] && bt) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) begin
            e.cht[i] = 1'b1;
            if (os[i]) run[i] = 0;
            else       rem[i] = per[i];
          end
        end
        e.busy[i] = run[i];
      end
      e.tick   = bt;
      last_cht = e.cht;
    end
`ifdef TICK_SCHED_FLAG_EN
    e.flag = flag_m;
`else
    e.flag = '0;
`endif
    q.push_back(e);
    @(negedge clk);
    cfg_we   = 1'b0;
    start    = '0;
    stop     = '0;
    flag_clr = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cfg(input int ch, input int p, input bit one);
    cfg_we      = 1'b1;
    cfg_ch      = 3'(ch);
    cfg_period  = PW'(p);
    cfg_oneshot = one;
  endtask

  // Monitor: every clock after stimulus, compare the DUT with the next entry.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{tick: tick_o, cht: ch_tick, busy: ch_busy, flag: ch_flag, err: cfg_err};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: got tick=%b ch_tick=%b busy=%b flag=%b err=%b, want tick=%b ch_tick=%b busy=%b flag=%b err=%b",
                   $time, a.tick, a.cht, a.busy, a.flag, a.err,
                   e.tick, e.cht, e.busy, e.flag, e.err);
        end
      end
    end
  end

  int pause_left;

  initial begin
    rst = 1'b1; pause = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    cfg_oneshot = 1'b0; start = '0; stop = '0; flag_clr = '0;
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(20);

    // Periodic channel 0, period 3.
    cfg(0, 3, 1'b0); step();
    start[0] = 1'b1; step();
    idle(40);

    // One-shot channel 1, period 2, configured and started together.
    cfg(1, 2, 1'b1); start[1] = 1'b1; step();
    idle(16);

    // Rejected writes: running channel and out-of-range index.
    cfg(0, 5, 1'b0); step();
    idle(2);
    cfg(6, 5, 1'b0); step();
    idle(13);

    // Stop channel 0 exactly on its expiring base tick.
    for (int k = 0; k < 100; k++) begin
      if (run[0] && rem[0] == 1 && phase == CLK_DIV - 1) break;
      step();
    end
    stop[0] = 1'b1; step();
    idle(8);

    // Zero-period start is ignored; then pause during a run.
    start[2] = 1'b1; step();
    idle(3);
    cfg(3, 4, 1'b0); step();
    start[3] = 1'b1; step();
    idle(5);
    pause = 1'b1; idle(10);
    pause = 1'b0; idle(25);

    // Flag clear coinciding with a visible ch_tick must not clear the flag.
    cfg(0, 3, 1'b0); step();
    start[0] = 1'b1; step();
    for (int k = 0; k < 100; k++) begin
      if (last_cht[0]) break;
      step();
    end
    flag_clr[0] = 1'b1; step();
    idle(6);
    flag_clr[0] = 1'b1; step();
    idle(6);

    // Reset mid-operation.
    rst = 1'b1; step();
    rst = 1'b0; idle(10);

    // Random traffic.
    pause_left = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (pause_left > 0) begin
        pause = 1'b1;
        pause_left--;
      end else begin
        pause = 1'b0;
        if ($urandom_range(0, 49) == 0) pause_left = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 5) == 0) begin
        cfg($urandom_range(0, 7), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < NCH; i++) begin
        start[i]    = ($urandom_range(0, 11) == 0);
        stop[i]     = ($urandom_range(0, 39) == 0);
        flag_clr[i] = ($urandom_range(0, 5) == 0);
      end
      step();
    end

    rst = 1'b0; pause = 1'b0;
    idle(4);
    repeat (2) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
